// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_request block: FSM states, access
// size encodings and load-extension helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DACC = 2'd1,
    ST_IACC = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int RAM_LAT_MAX = 15;

  function automatic logic [31:0] extend_byte(input logic [7:0] val, input logic zero_ext);
    return {{24{~zero_ext & val[7]}}, val};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] val, input logic zero_ext);
    return {{16{~zero_ext & val[15]}}, val};
  endfunction

endpackage

// File: rtl/mem_request_lane_align.sv
// Byte-lane steering between the 32-bit RAM word and right-aligned CPU data:
// byte enables, store replication and load extraction with extension.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        zero_ext,
  input  logic [31:0] store,
  input  logic [31:0] raw_load,
  output logic [3:0]  be,
  output logic [31:0] lane_store,
  output logic [31:0] load
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables and store replication; halves and words snap to the aligned lane
  always_comb begin
    be         = 4'b1111;
    lane_store = store;
    case (size)
      SIZE_BYTE: begin
        be         = 4'b0001 << lane;
        lane_store = {4{store[7:0]}};
      end
      SIZE_HALF: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        lane_store = {2{store[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        lane_store = store;
      end
    endcase
  end

  // Pick the addressed byte/half out of the RAM word and extend it
  always_comb begin
    byte_s = raw_load[7:0];
    case (lane)
      2'd0:    byte_s = raw_load[7:0];
      2'd1:    byte_s = raw_load[15:8];
      2'd2:    byte_s = raw_load[23:16];
      2'd3:    byte_s = raw_load[31:24];
      default: byte_s = raw_load[7:0];
    endcase
    if (lane[1]) begin
      half_s = raw_load[31:16];
    end else begin
      half_s = raw_load[15:0];
    end
    case (size)
      SIZE_BYTE: load = extend_byte(byte_s, zero_ext);
      SIZE_HALF: load = extend_half(half_s, zero_ext);
      default:   load = raw_load;
    endcase
  end

endmodule

// File: rtl/mem_request.sv
// Serialises instruction fetches and data loads/stores onto one fixed-latency
// RAM port; data wins arbitration, and a just-completed port yields for a cycle.
module mem_request
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [DATA_W-1:0] d_store,
  output logic              i_ready,
  output logic              d_ready,
  output logic [DATA_W-1:0] i_load,
  output logic [DATA_W-1:0] d_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load
);

  localparam int         LAT_C    = (RAM_LAT > RAM_LAT_MAX) ? RAM_LAT_MAX :
                                    ((RAM_LAT < 1) ? 1 : RAM_LAT);
  localparam logic [3:0] LAST_CNT = 4'(LAT_C - 1);

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              last_s;
  logic              d_pend_s, i_pend_s, access_s;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        size_r;
  logic              zext_r;
  logic [DATA_W-1:0] store_r;
  logic              wr_r;
  logic              i_ready_r, d_ready_r;
  logic [DATA_W-1:0] i_load_r, d_load_r;
  logic [3:0]        be_s;
  logic [31:0]       lane_store_s, load_s;

  // Next-state and access counter; the port whose ready is pulsing is masked
  // so its still-held request is not re-issued and the other port gets a turn
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    last_s   = 1'b0;
    d_pend_s = (d_ren | d_wen) & ~d_ready_r;
    i_pend_s = i_req & ~i_ready_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = 4'd0;
        if (d_pend_s) begin
          state_s = ST_DACC;
        end else if (i_pend_s) begin
          state_s = ST_IACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DACC, ST_IACC: begin
        if (cnt_r == LAST_CNT) begin
          last_s  = 1'b1;
          cnt_s   = 4'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Latch the winning request as the FSM leaves IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      size_r  <= SIZE_WORD;
      zext_r  <= 1'b1;
      store_r <= '0;
      wr_r    <= 1'b0;
    end else if (state_r == ST_IDLE && state_s == ST_DACC) begin
      addr_r  <= d_addr;
      size_r  <= d_size;
      zext_r  <= d_unsigned;
      store_r <= d_store;
      wr_r    <= d_wen;
    end else if (state_r == ST_IDLE && state_s == ST_IACC) begin
      addr_r  <= i_addr;
      size_r  <= SIZE_WORD;
      zext_r  <= 1'b1;
      store_r <= '0;
      wr_r    <= 1'b0;
    end
  end

  // Completion pulses and returned-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
      i_load_r  <= '0;
      d_load_r  <= '0;
    end else begin
      i_ready_r <= last_s & (state_r == ST_IACC);
      d_ready_r <= last_s & (state_r == ST_DACC);
      if (last_s && state_r == ST_IACC) begin
        i_load_r <= ram_load;
      end
      if (last_s && state_r == ST_DACC && !wr_r) begin
        d_load_r <= load_s;
      end
    end
  end

  lane_align u_lane_align (
    .size       (size_r),
    .lane       (addr_r[1:0]),
    .zero_ext   (zext_r),
    .store      (store_r),
    .raw_load   (ram_load),
    .be         (be_s),
    .lane_store (lane_store_s),
    .load       (load_s)
  );

  // RAM port is driven only from registered state and the latched request
  assign access_s  = (state_r == ST_DACC) || (state_r == ST_IACC);
  assign ram_addr  = access_s ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign ram_ren   = access_s & ~wr_r;
  assign ram_wen   = access_s & wr_r;
  assign ram_be    = access_s ? be_s : 4'b0000;
  assign ram_store = (access_s && wr_r) ? lane_store_s : '0;

  assign i_ready = i_ready_r;
  assign d_ready = d_ready_r;
  assign i_load  = i_load_r;
  assign d_load  = d_load_r;

endmodule

// File: tb/tb_mem_request.sv
// Directed bench for mem_request: one instance at RAM_LAT=2 for the functional
// vectors and one at RAM_LAT=1 for the alternating-arbitration case.
module tb_mem_request;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic        i_req, d_ren, d_wen, d_unsigned;
  logic [31:0] i_addr, d_addr, d_store;
  logic [1:0]  d_size;
  logic        i_ready, d_ready, ram_ren, ram_wen;
  logic [31:0] i_load, d_load, ram_addr, ram_store, ram_load;
  logic [3:0]  ram_be;

  logic        i_req_b, d_ren_b, d_wen_b, d_unsigned_b;
  logic [31:0] i_addr_b, d_addr_b, d_store_b;
  logic [1:0]  d_size_b;
  logic        i_ready_b, d_ready_b, ram_ren_b, ram_wen_b;
  logic [31:0] i_load_b, d_load_b, ram_addr_b, ram_store_b, ram_load_b;
  logic [3:0]  ram_be_b;

  logic [31:0] mem [0:63];
  int          ren_cnt, ren_cnt_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_request #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_ren(d_ren), .d_wen(d_wen),
    .d_addr(d_addr), .d_size(d_size), .d_unsigned(d_unsigned), .d_store(d_store),
    .i_ready(i_ready), .d_ready(d_ready), .i_load(i_load), .d_load(d_load),
    .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_be(ram_be),
    .ram_store(ram_store), .ram_load(ram_load)
  );

  mem_request #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .i_req(i_req_b), .i_addr(i_addr_b), .d_ren(d_ren_b), .d_wen(d_wen_b),
    .d_addr(d_addr_b), .d_size(d_size_b), .d_unsigned(d_unsigned_b), .d_store(d_store_b),
    .i_ready(i_ready_b), .d_ready(d_ready_b), .i_load(i_load_b), .d_load(d_load_b),
    .ram_addr(ram_addr_b), .ram_ren(ram_ren_b), .ram_wen(ram_wen_b), .ram_be(ram_be_b),
    .ram_store(ram_store_b), .ram_load(ram_load_b)
  );

  // RAM models: data is valid only in the RAM_LAT-th cycle of a continuous read strobe
  always @(posedge clk) begin
    ren_cnt   <= ram_ren ? ren_cnt + 1 : 0;
    ren_cnt_b <= ram_ren_b ? ren_cnt_b + 1 : 0;
  end
  assign ram_load   = (ram_ren && ren_cnt == 1) ? mem[ram_addr[7:2]] : 32'hDEAD_BEEF;
  assign ram_load_b = (ram_ren_b && ren_cnt_b == 0) ? mem[ram_addr_b[7:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete data load on the RAM_LAT=2 instance
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [3:0] exp_be, input logic [31:0] exp_load);
    d_ren = 1'b1; d_addr = addr; d_size = size; d_unsigned = uns;
    tick();
    chk("ld_be", 32'(ram_be), 32'(exp_be));
    tick();
    chk("ld_early_rdy", 32'(d_ready), 32'd0);
    tick();
    chk("ld_rdy", 32'(d_ready), 32'd1);
    chk("ld_data", d_load, exp_load);
    d_ren = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    for (int a = 0; a < 64; a++) mem[a] = 32'h0100_0000 + 32'(a);
    mem[4]  = 32'h00A0_0093;
    mem[16] = 32'h80FF_1234;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'd0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = 32'd0; d_size = 2'b10; d_unsigned = 1'b0; d_store = 32'd0;
    i_req_b = 1'b0; i_addr_b = 32'd0; d_ren_b = 1'b0; d_wen_b = 1'b0;
    d_addr_b = 32'd0; d_size_b = 2'b10; d_unsigned_b = 1'b0; d_store_b = 32'd0;
    tick(); tick();

    chk("rst_i_ready", 32'(i_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_i_load", i_load, 32'd0);
    chk("rst_d_load", d_load, 32'd0);
    chk("rst_ram", {ram_addr[27:0], ram_be}, 32'd0);
    chk("rst_ram_strobe", 32'({ram_ren, ram_wen}), 32'd0);
    rst = 1'b0;

    // Instruction fetch: ready three cycles after the request
    i_req = 1'b1; i_addr = 32'h0000_0010;
    tick();
    chk("if_addr", ram_addr, 32'h0000_0010);
    chk("if_ren_be", 32'({ram_ren, ram_wen, ram_be}), 32'b10_1111);
    tick();
    chk("if_early_rdy", 32'(i_ready), 32'd0);
    tick();
    chk("if_rdy", 32'(i_ready), 32'd1);
    chk("if_data", i_load, 32'h00A0_0093);
    i_req = 1'b0;
    tick();
    chk("if_rdy_pulse", 32'(i_ready), 32'd0);
    chk("if_idle_ram", 32'({ram_ren, ram_wen}), 32'd0);

    // Byte store to lane 3
    d_wen = 1'b1; d_size = 2'b00; d_addr = 32'h0000_0023; d_store = 32'h0000_00AB;
    tick();
    chk("st_addr", ram_addr, 32'h0000_0020);
    chk("st_be", 32'(ram_be), 32'b1000);
    chk("st_data", ram_store, 32'hABAB_ABAB);
    chk("st_strobe", 32'({ram_ren, ram_wen}), 32'b01);
    tick(); tick();
    chk("st_rdy", 32'(d_ready), 32'd1);
    chk("st_no_load", d_load, 32'd0);
    d_wen = 1'b0;
    tick();
    chk("st_idle_ram", {ram_store[27:0], ram_be}, 32'd0);

    // Half store to a misaligned address lands in the low half
    d_wen = 1'b1; d_size = 2'b01; d_addr = 32'h0000_0031; d_store = 32'h1234_5678;
    tick();
    chk("sth_be", 32'(ram_be), 32'b0011);
    chk("sth_data", ram_store, 32'h5678_5678);
    tick(); tick();
    d_wen = 1'b0;
    tick();

    // Loads from 0x80FF1234: sizes, lanes, extension and misalignment
    do_load(32'h42, 2'b01, 1'b0, 4'b1100, 32'hFFFF_80FF);
    do_load(32'h42, 2'b01, 1'b1, 4'b1100, 32'h0000_80FF);
    do_load(32'h43, 2'b00, 1'b0, 4'b1000, 32'hFFFF_FF80);
    do_load(32'h41, 2'b00, 1'b0, 4'b0010, 32'h0000_0012);
    do_load(32'h40, 2'b00, 1'b1, 4'b0001, 32'h0000_0034);
    do_load(32'h41, 2'b01, 1'b0, 4'b0011, 32'h0000_1234);
    do_load(32'h43, 2'b01, 1'b1, 4'b1100, 32'h0000_80FF);
    do_load(32'h43, 2'b10, 1'b0, 4'b1111, 32'h80FF_1234);
    do_load(32'h40, 2'b11, 1'b0, 4'b1111, 32'h80FF_1234);

    // Illegal read+write is a write and leaves d_load alone
    d_ren = 1'b1; d_wen = 1'b1; d_size = 2'b10; d_addr = 32'h10; d_store = 32'h5555_AAAA;
    tick();
    chk("rw_strobe", 32'({ram_ren, ram_wen}), 32'b01);
    tick(); tick();
    chk("rw_rdy", 32'(d_ready), 32'd1);
    chk("rw_no_load", d_load, 32'h80FF_1234);
    d_ren = 1'b0; d_wen = 1'b0;
    tick();

    // Simultaneous data and fetch: data first, fetch three cycles later
    d_ren = 1'b1; d_size = 2'b10; d_addr = 32'h10; d_unsigned = 1'b0;
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    chk("arb_first", ram_addr, 32'h10);
    tick(); tick();
    chk("arb_d_rdy", 32'({d_ready, i_ready}), 32'b10);
    chk("arb_d_data", d_load, 32'h00A0_0093);
    d_ren = 1'b0;
    tick();
    chk("arb_second", ram_addr, 32'h40);
    chk("arb_gap_rdy", 32'({d_ready, i_ready}), 32'b00);
    tick(); tick();
    chk("arb_i_rdy", 32'({d_ready, i_ready}), 32'b01);
    chk("arb_i_data", i_load, 32'h80FF_1234);
    i_req = 1'b0;
    tick();

    // Reset in the second access cycle aborts; the held request restarts
    d_ren = 1'b1; d_addr = 32'h10; d_size = 2'b10;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_rdy", 32'(d_ready), 32'd0);
    chk("rst_mid_ram", ram_addr, 32'd0);
    chk("rst_mid_strobe", 32'({ram_ren, ram_wen, ram_be}), 32'd0);
    chk("rst_mid_load", d_load, 32'd0);
    tick();
    chk("rst_restart_ren", 32'(ram_ren), 32'd1);
    tick();
    chk("rst_restart_early", 32'(d_ready), 32'd0);
    tick();
    chk("rst_restart_rdy", 32'(d_ready), 32'd1);
    chk("rst_restart_data", d_load, 32'h00A0_0093);
    d_ren = 1'b0;
    tick();

    // RAM_LAT=1 with both ports held: D, gap, I, gap, ...
    d_ren_b = 1'b1; d_addr_b = 32'h10; d_size_b = 2'b10;
    i_req_b = 1'b1; i_addr_b = 32'h40;
    for (int k = 0; k <= 12; k++) begin
      logic [31:0] e_addr;
      logic        e_drdy, e_irdy;
      e_addr = (k % 4 == 1) ? 32'h10 : ((k % 4 == 3) ? 32'h40 : 32'h0);
      e_drdy = (k > 0) && (k % 4 == 2);
      e_irdy = (k > 0) && (k % 4 == 0);
      chk("alt_addr", ram_addr_b, e_addr);
      chk("alt_ren", 32'(ram_ren_b), 32'(k % 2));
      chk("alt_rdy", 32'({d_ready_b, i_ready_b}), 32'({e_drdy, e_irdy}));
      tick();
    end
    chk("alt_d_data", d_load_b, 32'h00A0_0093);
    chk("alt_i_data", i_load_b, 32'h80FF_1234);
    chk("alt_no_write", 32'({ram_wen_b, ram_be_b[0]}) & 32'd2, 32'd0);
    chk("alt_no_store", ram_store_b, 32'd0);
    d_ren_b = 1'b0; i_req_b = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
